mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store stage directly downstream of the single-cycle core's execute logic. Owns the data bus (dbus) on the core's behalf.
- Accepts one memory operation from execute: effective address, store data, access size, signedness.
- Drives a byte-accurate dbus request (size, strobe, lane-shifted data) and holds it stable until data_ok.
- Returns the aligned, sign- or zero-extended load result to the writeback mux as a one-cycle response.

Parameters:
- MISALIGN_CHECK, 1: when 1, misaligned accesses are refused with resp_misalign and no bus activity; when 0, no alignment check.
- TIMEOUT_CYCLES, 0: if nonzero, a BUSY transaction with no data_ok after this many cycles is aborted with resp_timeout; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute presents an operation.
- req_ready  out  1  unit can accept an operation this cycle.
- req_load  in  1  operation is a load.
- req_store  in  1  operation is a store.
- req_size  in  2  access size: 0=byte, 1=half, 2=word, 3=dword.
- req_unsigned  in  1  zero-extend the load result (LBU/LHU/LWU).
- req_addr  in  64  effective address (u64).
- req_wdata  in  64  store data, right-aligned (u64).
- resp_valid  out  1  result is valid; one-cycle pulse.
- resp_rdata  out  64  extended load data; 0 for stores and errors.
- resp_misalign  out  1  qualifies resp_valid: access was refused as misaligned.
- resp_timeout  out  1  qualifies resp_valid: watchdog abort.
- dreq  out  dbus_req_t  data bus request.
- dresp  in  dbus_resp_t  data bus response.

Behaviour:
- States: IDLE, BUSY, RESP.
- req_ready = (state==IDLE).
- dreq.valid = (state==BUSY).
- resp_valid = (state==RESP).
- IDLE, req_valid with neither load nor store set: request ignored, state stays IDLE.
- Store priority: if both req_load and req_store are set, the request is handled as a store.
- Misalignment: half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0.
- IDLE accept, misaligned and MISALIGN_CHECK=1: go to RESP with resp_misalign=1; no dreq is issued.
- IDLE accept, otherwise: latch dreq fields and go to BUSY.
- Latched dreq.addr: req_addr, unmodified.
- Latched dreq.size: MSIZE1/2/4/8 for req_size 0/1/2/3.
- Latched dreq.strobe for stores: base mask 8'h01/8'h03/8'h0F/8'hFF for sizes 0/1/2/3, shifted left by addr[2:0], truncated to 8 bits.
- Latched dreq.strobe for loads: 0.
- Latched dreq.data: req_wdata shifted left by 8*addr[2:0].
- BUSY: all dreq fields are held constant from the latch.
- BUSY, dresp.data_ok=1: register the result and go to RESP.
- Store result: resp_rdata=0.
- Load result: dresp.data shifted right by 8*addr[2:0], truncated to size, then extended.
- Extension: sign-extend when req_unsigned=0, zero-extend when req_unsigned=1; req_unsigned is ignored for dword.
- Watchdog: in BUSY a counter increments each cycle and clears on entry to BUSY. When TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES without data_ok, go to RESP with resp_timeout=1 and resp_rdata=0.
- RESP lasts exactly one cycle, then IDLE. New requests are not accepted in RESP.
- resp_rdata, resp_misalign and resp_timeout are registered. They hold their value outside RESP and are cleared on the next accept.
- dresp.data_ok is ignored in IDLE and RESP; stray or late responses have no effect.
- Minimum latency: accept at cycle N; dreq.valid at N+1; if data_ok at N+1, resp_valid at N+2.
- Misaligned refusal: resp_valid at N+1.
- Reset (asynchronous, active-low), asserted in any state: state=IDLE immediately.
- Reset values: dreq.valid=0, resp_valid=0, resp_rdata=0, resp_misalign=0, resp_timeout=0, all latched dreq fields=0, watchdog counter=0, req_ready=1.
- Reset in BUSY abandons the transaction; a later data_ok is ignored.

Test Plan:
- Load byte, signed: addr=0x80001003, size=0, unsigned=0, dresp.data=0x00000000_80000000 with data_ok in the first BUSY cycle -> dreq.size=MSIZE1, strobe=0, resp_valid two cycles after accept, resp_rdata=0xFFFFFFFF_FFFFFF80.
- Load byte, unsigned: same stimulus with unsigned=1 -> resp_rdata=0x80.
- Store half: addr=0x80002006, wdata=0x1234, size=1 -> dreq.strobe=8'hC0, dreq.data=0x1234_0000_0000_0000.
- Store with delayed response: same store, data_ok withheld 3 cycles -> dreq fields stable across all BUSY cycles and req_ready=0; then resp_valid with resp_rdata=0.
- Misaligned word load: addr=0x80000002, size=2, MISALIGN_CHECK=1 -> dreq.valid never asserted; resp_valid one cycle after accept with resp_misalign=1 and resp_rdata=0.
- Watchdog: TIMEOUT_CYCLES=4, no data_ok -> resp_timeout=1 on the cycle after the 4th BUSY cycle.
- Reset mid-BUSY: assert reset low in BUSY -> dreq.valid=0 immediately. After release, req_ready=1; a stray data_ok produces no resp_valid.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Execute-side request/response handshake plus the data bus (dbus) owned by the
// load/store unit.
interface mem_access_unit_if;
  // dbus access sizes; the code equals log2 of the byte count
  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_timeout;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;

  modport master (
    output req_valid, req_load, req_store, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misalign, resp_timeout,
    input  dreq,
    output dresp
  );

  modport slave (
    input  req_valid, req_load, req_store, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misalign, resp_timeout,
    output dreq,
    input  dresp
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: turns one execute-stage memory op into a byte-lane dbus
// transaction and returns the aligned, extended result as a one-cycle response.
module mem_access_unit #(
  parameter bit          MISALIGN_CHECK = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_next;

  logic [63:0]      addr_q;
  logic [1:0]       size_q;
  logic [7:0]       strobe_q;
  logic [63:0]      data_q;
  logic             store_q;
  logic             unsigned_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      rdata_q;
  logic             misalign_q;
  logic             timeout_q;

  logic        accept_c;
  logic        misaligned_c;
  logic        refuse_c;
  logic        timeout_hit_c;
  logic [7:0]  base_mask_c;
  logic [7:0]  strobe_c;
  logic [63:0] lane_c;
  logic [63:0] load_c;

  // Request decode: alignment, byte-lane strobe and watchdog expiry
  always_comb begin
    accept_c = (state == IDLE) && bus.req_valid && (bus.req_load || bus.req_store);
    misaligned_c = 1'b0;
    base_mask_c  = 8'h01;
    case (bus.req_size)
      2'd1: begin misaligned_c = bus.req_addr[0];      base_mask_c = 8'h03; end
      2'd2: begin misaligned_c = |bus.req_addr[1:0];   base_mask_c = 8'h0F; end
      2'd3: begin misaligned_c = |bus.req_addr[2:0];   base_mask_c = 8'hFF; end
      default: ;
    endcase
    refuse_c = MISALIGN_CHECK && misaligned_c;
    strobe_c = bus.req_store ? 8'(base_mask_c << bus.req_addr[2:0]) : 8'h00;
    timeout_hit_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Load data: move the addressed lane to bit 0, then extend to 64 bits
  always_comb begin
    lane_c = bus.dresp.data >> {addr_q[2:0], 3'b000};
    case (size_q)
      2'd0:    load_c = unsigned_q ? {56'd0, lane_c[7:0]}  : {{56{lane_c[7]}},  lane_c[7:0]};
      2'd1:    load_c = unsigned_q ? {48'd0, lane_c[15:0]} : {{48{lane_c[15]}}, lane_c[15:0]};
      2'd2:    load_c = unsigned_q ? {32'd0, lane_c[31:0]} : {{32{lane_c[31]}}, lane_c[31:0]};
      default: load_c = lane_c;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c) state_next = refuse_c ? RESP : BUSY;
      BUSY:    if (bus.dresp.data_ok || timeout_hit_c) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The size code reuses the request encoding since MSIZEn is log2 of the byte count
  always_comb begin
    bus.req_ready     = (state == IDLE);
    bus.resp_valid    = (state == RESP);
    bus.resp_rdata    = rdata_q;
    bus.resp_misalign = misalign_q;
    bus.resp_timeout  = timeout_q;
    bus.dreq          = '0;
    bus.dreq.valid    = (state == BUSY);
    bus.dreq.addr     = addr_q;
    bus.dreq.size     = {1'b0, size_q};
    bus.dreq.strobe   = strobe_q;
    bus.dreq.data     = data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      size_q     <= '0;
      strobe_q   <= '0;
      data_q     <= '0;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (accept_c) begin
      addr_q     <= bus.req_addr;
      size_q     <= bus.req_size;
      strobe_q   <= strobe_c;
      data_q     <= bus.req_wdata << {bus.req_addr[2:0], 3'b000};
      store_q    <= bus.req_store;
      unsigned_q <= bus.req_unsigned;
      cnt_q      <= '0;
      rdata_q    <= '0;
      misalign_q <= refuse_c;
      timeout_q  <= 1'b0;
    end else if (state == BUSY) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (bus.dresp.data_ok) rdata_q <= store_q ? 64'd0 : load_c;
      else if (timeout_hit_c) timeout_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-level reference model.
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.MISALIGN_CHECK(1'b1), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic bit model_misaligned(input logic [1:0] size, input logic [63:0] addr);
    return (addr % (64'd1 << size)) != 64'd0;
  endfunction

  function automatic logic [7:0] model_strobe(input logic store, input logic [1:0] size,
                                              input logic [63:0] addr);
    logic [7:0] s = 8'h00;
    int off = int'(addr % 64'd8);
    int n = 1 << size;
    if (store)
      for (int b = 0; b < 8; b++)
        if (b >= off && b < off + n) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] bus_data, input logic [1:0] size,
                                             input logic uns, input logic [63:0] addr);
    int nbits = 8 << size;
    int off = int'(addr % 64'd8);
    logic [63:0] v = bus_data >> (8 * off);
    if (nbits < 64) begin
      v = v & ((64'd1 << nbits) - 64'd1);
      if (!uns && v[nbits-1]) v = v | ~((64'd1 << nbits) - 64'd1);
    end
    return v;
  endfunction

  // One complete operation; delay = BUSY cycle index (0-based) in which data_ok is given
  task automatic run_op(input logic ld, input logic st, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata_bus, input int delay);
    bit active = ld || st;
    bit is_store = st;
    bit refused = active && model_misaligned(size, addr);
    bit done = 1'b0;
    logic [63:0] exp_data = wdata << (8 * int'(addr % 64'd8));
    logic [7:0]  exp_strobe = model_strobe(is_store, size, addr);
    logic [63:0] exp_rdata = is_store ? 64'd0 : model_load(rdata_bus, size, uns, addr);
    @(negedge clk);
    check("ready_idle", bus.req_ready, 1);
    bus.req_load = ld; bus.req_store = st; bus.req_size = size; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (!active) begin
      check("ignored_dvalid", bus.dreq.valid, 0);
      check("ignored_ready", bus.req_ready, 1);
      check("ignored_resp", bus.resp_valid, 0);
      return;
    end
    if (refused) begin
      check("mis_dvalid", bus.dreq.valid, 0);
      check("mis_resp_valid", bus.resp_valid, 1);
      check("mis_flag", bus.resp_misalign, 1);
      check("mis_rdata", bus.resp_rdata, 0);
      check("mis_timeout", bus.resp_timeout, 0);
      @(negedge clk);
      check("mis_resp_end", bus.resp_valid, 0);
      check("mis_ready", bus.req_ready, 1);
      return;
    end
    for (int k = 0; k < 8 && !done; k++) begin
      check("busy_dvalid", bus.dreq.valid, 1);
      check("busy_ready", bus.req_ready, 0);
      check("busy_addr", bus.dreq.addr, addr);
      check("busy_size", bus.dreq.size, 64'(size));
      check("busy_strobe", bus.dreq.strobe, exp_strobe);
      check("busy_data", bus.dreq.data, exp_data);
      if (k == delay) begin
        bus.dresp.data_ok = 1'b1;
        bus.dresp.data = rdata_bus;
      end
      @(negedge clk);
      bus.dresp.data_ok = 1'b0;
      bus.dresp.data = {$urandom, $urandom};
      if (k == delay) begin
        check("resp_valid", bus.resp_valid, 1);
        check("resp_rdata", bus.resp_rdata, exp_rdata);
        check("resp_misalign", bus.resp_misalign, 0);
        check("resp_timeout", bus.resp_timeout, 0);
        done = 1'b1;
      end else if (k == TMO - 1) begin
        check("tmo_valid", bus.resp_valid, 1);
        check("tmo_flag", bus.resp_timeout, 1);
        check("tmo_rdata", bus.resp_rdata, 0);
        check("tmo_dvalid", bus.dreq.valid, 0);
        done = 1'b1;
      end
    end
    check("op_bounded", 64'(done), 1);
    @(negedge clk);
    check("resp_one_cycle", bus.resp_valid, 0);
    check("back_to_idle", bus.req_ready, 1);
  endtask

  task automatic reset_mid_busy();
    @(negedge clk);
    bus.req_load = 1'b1; bus.req_store = 1'b0; bus.req_size = 2'd3; bus.req_unsigned = 1'b0;
    bus.req_addr = 64'h8000_1000; bus.req_wdata = 64'd0; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst_pre_busy", bus.dreq.valid, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_dvalid", bus.dreq.valid, 0);
    check("rst_ready", bus.req_ready, 1);
    check("rst_resp", bus.resp_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    bus.dresp.data_ok = 1'b1;
    bus.dresp.data = 64'hDEAD_BEEF_0000_0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_resp", bus.resp_valid, 0);
      check("stray_ready", bus.req_ready, 1);
      check("stray_dvalid", bus.dreq.valid, 0);
    end
    bus.dresp.data_ok = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_store = 1'b0;
    bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 64'd0; bus.req_wdata = 64'd0;
    bus.dresp = '0;
    #12;
    check("rst_ready0", bus.req_ready, 1);
    check("rst_dvalid0", bus.dreq.valid, 0);
    check("rst_resp0", bus.resp_valid, 0);
    check("rst_rdata0", bus.resp_rdata, 0);
    check("rst_mis0", bus.resp_misalign, 0);
    check("rst_tmo0", bus.resp_timeout, 0);
    check("rst_strobe0", bus.dreq.strobe, 0);
    check("rst_addr0", bus.dreq.addr, 0);
    @(negedge clk);
    reset = 1'b1;

    run_op(1, 0, 2'd0, 0, 64'h8000_1003, 64'h55, 64'h0000_0000_8000_0000, 0);
    run_op(1, 0, 2'd0, 1, 64'h8000_1003, 64'h55, 64'h0000_0000_8000_0000, 0);
    run_op(0, 1, 2'd1, 0, 64'h8000_2006, 64'h1234, 64'h0, 0);
    run_op(0, 1, 2'd1, 0, 64'h8000_2006, 64'h1234, 64'h0, 3);
    run_op(1, 0, 2'd2, 0, 64'h8000_0002, 64'h0, 64'h0, 0);
    run_op(1, 0, 2'd3, 0, 64'h8000_0008, 64'h0, 64'h1, 20);
    run_op(1, 1, 2'd2, 0, 64'h8000_0004, 64'hCAFE_F00D, 64'h0, 1);
    run_op(0, 0, 2'd2, 0, 64'h8000_0004, 64'h0, 64'h0, 0);
    reset_mid_busy();

    for (int i = 0; i < 80; i++) begin
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic [63:0] a = {$urandom, $urandom};
      int          sel = int'($urandom_range(0, 9));
      if ($urandom_range(0, 1) == 0) a = a & ~((64'd1 << sz) - 64'd1);
      run_op(sel < 5 || sel == 9, sel >= 5, sz, 1'($urandom_range(0, 1)), a,
             {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
